// File: rtl/panda_pkg.sv
// Shared types for the panda core.
// Holds the decode select/operator enums consumed by the datapath, the
// multi-cycle datapath state enum, and the packed bundle of latched controls.
// No ports.
package panda_pkg;

  typedef enum logic {OP_A_RS1, OP_A_PC} op_a_sel_e;
  typedef enum logic {OP_B_RS2, OP_B_IMM} op_b_sel_e;

  typedef enum logic [1:0] {
    RD_SEL_ALU, RD_SEL_LOAD, RD_SEL_PC_INC, RD_SEL_IMM
  } rd_data_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE
  } alu_operator_e;

  typedef enum logic [1:0] {LSU_BYTE, LSU_HALF, LSU_WORD} lsu_width_e;

  typedef enum logic [1:0] {
    MC_IDLE, MC_EXEC, MC_MEM_REQ, MC_MEM_WAIT
  } mc_state_e;

  typedef struct packed {
    op_a_sel_e     op_a_sel;
    op_b_sel_e     op_b_sel;
    rd_data_sel_e  rd_data_sel;
    alu_operator_e alu_operator;
    logic          lsu_store;
    lsu_width_e    lsu_width;
    logic          load_unsigned;
    logic          rd_we;
  } mc_ctrl_t;

  function automatic logic is_mem_op(mc_ctrl_t c);
    return c.lsu_store || (c.rd_data_sel == RD_SEL_LOAD);
  endfunction

endpackage

// File: rtl/panda_alu.sv
// Combinational integer ALU. Compare operators return 0/1 in bit 0 so the
// result can double as a branch condition.
// Ports: operator_i (function), operand_a_i/operand_b_i (32-bit operands),
//        result_o (32-bit result).
module panda_alu
  import panda_pkg::*;
(
  input  alu_operator_e operator_i,
  input  logic [31:0]   operand_a_i,
  input  logic [31:0]   operand_b_i,
  output logic [31:0]   result_o
);

  logic [4:0] shamt;
  assign shamt = operand_b_i[4:0];

  always_comb begin
    result_o = '0;
    case (operator_i)
      ALU_ADD:  result_o = operand_a_i + operand_b_i;
      ALU_SUB:  result_o = operand_a_i - operand_b_i;
      ALU_AND:  result_o = operand_a_i & operand_b_i;
      ALU_OR:   result_o = operand_a_i | operand_b_i;
      ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
      ALU_SLL:  result_o = operand_a_i << shamt;
      ALU_SRL:  result_o = operand_a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(operand_a_i) >>> shamt);
      ALU_SLT:  result_o = {31'b0, $signed(operand_a_i) < $signed(operand_b_i)};
      ALU_SLTU: result_o = {31'b0, operand_a_i < operand_b_i};
      ALU_EQ:   result_o = {31'b0, operand_a_i == operand_b_i};
      ALU_NE:   result_o = {31'b0, operand_a_i != operand_b_i};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/panda_mc_lsu.sv
// Load/store lane logic: byte enables, store-data lane replication, and
// load lane selection with sign/zero extension.
// Optional feature macro: PANDA_MISALIGNED_CHECK_EN -- when defined,
// misaligned_o flags half accesses with offset[0]=1 and word accesses with a
// non-zero offset; otherwise it is tied 0 (half uses offset[1] only, word
// ignores the offset).
// Ports: width_i, offset_i (addr[1:0]), load_unsigned_i, store_data_i,
//        rdata_i, be_o, wdata_o, load_data_o, misaligned_o.
module panda_mc_lsu
  import panda_pkg::*;
(
  input  lsu_width_e  width_i,
  input  logic [1:0]  offset_i,
  input  logic        load_unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[8*offset_i +: 8];
  assign half_lane = rdata_i[16*offset_i[1] +: 16];

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    load_data_o = rdata_i;
    case (width_i)
      LSU_BYTE: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = load_unsigned_i ? {24'b0, byte_lane}
                                      : {{24{byte_lane[7]}}, byte_lane};
      end
      LSU_HALF: begin
        be_o        = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = load_unsigned_i ? {16'b0, half_lane}
                                      : {{16{half_lane[15]}}, half_lane};
      end
      default: ;
    endcase
  end

`ifdef PANDA_MISALIGNED_CHECK_EN
  assign misaligned_o = ((width_i == LSU_HALF) && offset_i[0]) ||
                        ((width_i != LSU_BYTE) && (width_i != LSU_HALF) && (offset_i != 2'b00));
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/panda_register_file.sv
// Two-read, one-write register file. x0 and out-of-range addresses read as
// zero and ignore writes. Reset clears every entry.
// Ports: clk_i, rst_ni (async active-low), raddr_a_i/rdata_a_o,
//        raddr_b_i/rdata_b_o (combinational reads), waddr_i/wdata_i/we_i.
module panda_register_file #(
  parameter int Depth = 32,
  parameter int Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [$clog2(Depth)-1:0] raddr_a_i,
  output logic [Width-1:0]         rdata_a_o,
  input  logic [$clog2(Depth)-1:0] raddr_b_i,
  output logic [Width-1:0]         rdata_b_o,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     we_i
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= '{default: '0};
    end else if (we_i && (waddr_i != '0) && (int'(waddr_i) < Depth)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = ((raddr_a_i == '0) || (int'(raddr_a_i) >= Depth)) ? '0 : mem[raddr_a_i];
  assign rdata_b_o = ((raddr_b_i == '0) || (int'(raddr_b_i) >= Depth)) ? '0 : mem[raddr_b_i];

endmodule

// File: rtl/panda_mc_datapath.sv
// Multi-cycle execution datapath: latches one instruction's controls, runs
// it through the register file and ALU, and performs at most one memory
// access before retiring with a one-cycle done_o pulse.
// Optional feature macro: PANDA_MISALIGNED_CHECK_EN (misaligned accesses
// retire in EXEC with misaligned_o=1, no request and no register write).
// Ports: clk_i, rst_ni (async active-low); valid_i/ready_o control handshake;
//        rs1/rs2/rd addresses, rd_we_i, operand/writeback selects,
//        alu_operator_i, lsu_store_i, lsu_width_i, lsu_load_unsigned_i,
//        pc_i, imm_i; data_* memory request/response port; done_o,
//        jump_target_o, branch_cond_o, misaligned_o retire outputs.
//
// state       | meaning
// MC_IDLE     | ready_o=1, waiting for valid_i
// MC_EXEC     | regfile read + ALU; retire or register memory request
// MC_MEM_REQ  | data_req_o held until data_gnt_i
// MC_MEM_WAIT | waiting for data_rvalid_i, then retire
module panda_mc_datapath
  import panda_pkg::*;
#(
  parameter int NumRegs = 32,
  parameter int Width   = 32,
  localparam int RegAw  = $clog2(NumRegs)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [RegAw-1:0]  rs1_addr_i,
  input  logic [RegAw-1:0]  rs2_addr_i,
  input  logic [RegAw-1:0]  rd_addr_i,
  input  logic              rd_we_i,
  input  op_a_sel_e         op_a_sel_i,
  input  op_b_sel_e         op_b_sel_i,
  input  rd_data_sel_e      rd_data_sel_i,
  input  alu_operator_e     alu_operator_i,
  input  logic              lsu_store_i,
  input  lsu_width_e        lsu_width_i,
  input  logic              lsu_load_unsigned_i,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       imm_i,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [31:0]       data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i,
  output logic              done_o,
  output logic [31:0]       jump_target_o,
  output logic              branch_cond_o,
  output logic              misaligned_o
);

  if (Width != 32) begin : gen_width_chk
    $error("panda_mc_datapath: Width must be 32");
  end
  if ((NumRegs != 16) && (NumRegs != 32)) begin : gen_regs_chk
    $error("panda_mc_datapath: NumRegs must be 16 or 32");
  end

  mc_state_e        state_q, state_d;
  mc_ctrl_t         ctrl_q;
  logic [RegAw-1:0] rs1_q, rs2_q, rd_q;
  logic [31:0]      pc_q, imm_q, addr_q, wdata_q;
  logic [3:0]       be_q;
  logic             we_q;

  logic [Width-1:0] rs1_data, rs2_data, rd_wdata;
  logic [31:0]      op_a, op_b, alu_result, load_data, lsu_wdata;
  logic [3:0]       lsu_be;
  logic [1:0]       lsu_offset;
  logic             lsu_mis, mem_op, rf_we;

  assign mem_op = is_mem_op(ctrl_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= MC_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE:     if (valid_i) state_d = MC_EXEC;
      MC_EXEC:     state_d = (mem_op && !lsu_mis) ? MC_MEM_REQ : MC_IDLE;
      MC_MEM_REQ:  if (data_gnt_i) state_d = MC_MEM_WAIT;
      MC_MEM_WAIT: if (data_rvalid_i) state_d = MC_IDLE;
      default:     state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    ready_o      = 1'b0;
    data_req_o   = 1'b0;
    done_o       = 1'b0;
    misaligned_o = 1'b0;
    rf_we        = 1'b0;
    case (state_q)
      MC_IDLE:    ready_o = 1'b1;
      MC_EXEC: begin
        // A misaligned memory op retires here without touching memory.
        done_o       = !mem_op || lsu_mis;
        misaligned_o = mem_op && lsu_mis;
        rf_we        = ctrl_q.rd_we && !mem_op;
      end
      MC_MEM_REQ: data_req_o = 1'b1;
      MC_MEM_WAIT: begin
        done_o = data_rvalid_i;
        rf_we  = ctrl_q.rd_we && data_rvalid_i && !ctrl_q.lsu_store;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      pc_q   <= '0;
      imm_q  <= '0;
    end else if (valid_i && ready_o) begin
      ctrl_q <= '{op_a_sel: op_a_sel_i, op_b_sel: op_b_sel_i,
                  rd_data_sel: rd_data_sel_i, alu_operator: alu_operator_i,
                  lsu_store: lsu_store_i, lsu_width: lsu_width_i,
                  load_unsigned: lsu_load_unsigned_i, rd_we: rd_we_i};
      rs1_q  <= rs1_addr_i;
      rs2_q  <= rs2_addr_i;
      rd_q   <= rd_addr_i;
      pc_q   <= pc_i;
      imm_q  <= imm_i;
    end
  end

  // Request fields are frozen in EXEC so they stay stable while waiting for grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if ((state_q == MC_EXEC) && mem_op) begin
      addr_q  <= alu_result;
      wdata_q <= lsu_wdata;
      be_q    <= lsu_be;
      we_q    <= ctrl_q.lsu_store;
    end
  end

  assign data_addr_o  = {addr_q[31:2], 2'b00};
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;

  assign op_a = (ctrl_q.op_a_sel == OP_A_PC)  ? pc_q  : rs1_data;
  assign op_b = (ctrl_q.op_b_sel == OP_B_IMM) ? imm_q : rs2_data;

  // EXEC needs the fresh ALU offset for enables; the load response uses the frozen one.
  assign lsu_offset = (state_q == MC_EXEC) ? alu_result[1:0] : addr_q[1:0];

  always_comb begin
    case (ctrl_q.rd_data_sel)
      RD_SEL_LOAD:   rd_wdata = load_data;
      RD_SEL_PC_INC: rd_wdata = pc_q + 32'd4;
      RD_SEL_IMM:    rd_wdata = imm_q;
      default:       rd_wdata = alu_result;
    endcase
  end

  assign jump_target_o = {alu_result[31:1], 1'b0};
  assign branch_cond_o = alu_result[0];

  panda_register_file #(.Depth(NumRegs), .Width(Width)) u_regfile (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .raddr_a_i (rs1_q),
    .rdata_a_o (rs1_data),
    .raddr_b_i (rs2_q),
    .rdata_b_o (rs2_data),
    .waddr_i   (rd_q),
    .wdata_i   (rd_wdata),
    .we_i      (rf_we)
  );

  panda_alu u_alu (
    .operator_i  (ctrl_q.alu_operator),
    .operand_a_i (op_a),
    .operand_b_i (op_b),
    .result_o    (alu_result)
  );

  panda_mc_lsu u_lsu (
    .width_i         (ctrl_q.lsu_width),
    .offset_i        (lsu_offset),
    .load_unsigned_i (ctrl_q.load_unsigned),
    .store_data_i    (rs2_data),
    .rdata_i         (data_rdata_i),
    .be_o            (lsu_be),
    .wdata_o         (lsu_wdata),
    .load_data_o     (load_data),
    .misaligned_o    (lsu_mis)
  );

endmodule

// File: tb/tb_panda_mc_datapath.sv
`timescale 1ns/1ps
module tb_panda_mc_datapath;
  import panda_pkg::*;

  localparam int RegAw = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_o;
  logic [RegAw-1:0] rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic             rd_we_i = 1'b0;
  op_a_sel_e        op_a_sel_i = OP_A_RS1;
  op_b_sel_e        op_b_sel_i = OP_B_RS2;
  rd_data_sel_e     rd_data_sel_i = RD_SEL_ALU;
  alu_operator_e    alu_operator_i = ALU_ADD;
  logic             lsu_store_i = 1'b0;
  lsu_width_e       lsu_width_i = LSU_WORD;
  logic             lsu_load_unsigned_i = 1'b0;
  logic [31:0]      pc_i = '0, imm_i = '0;
  logic             data_req_o, data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0]      data_addr_o, data_wdata_o, data_rdata_i = '0;
  logic             data_we_o;
  logic [3:0]       data_be_o;
  logic             done_o, branch_cond_o, misaligned_o;
  logic [31:0]      jump_target_o;

  int n_tests = 0;
  int n_fail  = 0;

  panda_mc_datapath dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rd_we_i(rd_we_i), .op_a_sel_i(op_a_sel_i), .op_b_sel_i(op_b_sel_i),
    .rd_data_sel_i(rd_data_sel_i), .alu_operator_i(alu_operator_i),
    .lsu_store_i(lsu_store_i), .lsu_width_i(lsu_width_i),
    .lsu_load_unsigned_i(lsu_load_unsigned_i), .pc_i(pc_i), .imm_i(imm_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .done_o(done_o),
    .jump_target_o(jump_target_o), .branch_cond_o(branch_cond_o),
    .misaligned_o(misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_ctrl(input logic [RegAw-1:0] rs1, input logic [RegAw-1:0] rs2,
                          input logic [RegAw-1:0] rd, input logic we,
                          input op_a_sel_e a, input op_b_sel_e b,
                          input rd_data_sel_e rsel, input alu_operator_e op,
                          input logic store, input lsu_width_e w, input logic uns,
                          input logic [31:0] pc, input logic [31:0] imm);
    rs1_addr_i = rs1; rs2_addr_i = rs2; rd_addr_i = rd; rd_we_i = we;
    op_a_sel_i = a; op_b_sel_i = b; rd_data_sel_i = rsel; alu_operator_i = op;
    lsu_store_i = store; lsu_width_i = w; lsu_load_unsigned_i = uns;
    pc_i = pc; imm_i = imm;
  endtask

  task automatic launch();
    int guard;
    guard = 0;
    while (!ready_o && guard < 20) begin
      tick();
      guard++;
    end
    check("launch_ready", ready_o === 1'b1);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic write_imm(input logic [RegAw-1:0] rd, input logic [31:0] val);
    set_ctrl(0, 0, rd, 1'b1, OP_A_RS1, OP_B_IMM, RD_SEL_IMM, ALU_ADD, 1'b0, LSU_WORD, 1'b0, 32'h0, val);
    launch();
    tick();
  endtask

  task automatic mem_store(input logic [RegAw-1:0] rs2, input lsu_width_e w, input logic [31:0] addr,
                           output logic [31:0] a_obs, output logic [3:0] be_obs,
                           output logic we_obs, output logic [31:0] wd_obs);
    set_ctrl(0, rs2, 0, 1'b0, OP_A_RS1, OP_B_IMM, RD_SEL_ALU, ALU_ADD, 1'b1, w, 1'b0, 32'h0, addr);
    launch();
    tick();
    a_obs = data_addr_o; be_obs = data_be_o; we_obs = data_we_o; wd_obs = data_wdata_o;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
  endtask

  task automatic read_reg(input logic [RegAw-1:0] r, output logic [31:0] val);
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    mem_store(r, LSU_WORD, 32'h200, a, be, we, val);
  endtask

  task automatic mem_load(input logic [RegAw-1:0] rd, input lsu_width_e w, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          output logic [31:0] a_obs, output logic [3:0] be_obs,
                          output logic done_obs, output logic mis_obs);
    set_ctrl(0, 0, rd, 1'b1, OP_A_RS1, OP_B_IMM, RD_SEL_LOAD, ALU_ADD, 1'b0, w, uns, 32'h0, addr);
    launch();
    tick();
    a_obs = data_addr_o; be_obs = data_be_o;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    data_rdata_i = rdata;
    data_rvalid_i = 1'b1;
    #1;
    done_obs = done_o; mis_obs = misaligned_o;
    tick();
    data_rvalid_i = 1'b0;
  endtask

  logic [31:0] rv, a_obs, wd_obs;
  logic [3:0]  be_obs;
  logic        we_obs, done_obs, mis_obs;
  int          req_cycles;

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", ready_o === 1'b1);
    check("rst_req", data_req_o === 1'b0);
    check("rst_done", done_o === 1'b0);
    check("rst_we", data_we_o === 1'b0);
    check("rst_be", data_be_o === 4'b0000);
    rst_ni = 1'b1;
    tick();

    write_imm(0, 32'h55);
    read_reg(0, rv);
    check("x0_read", rv === 32'h0);

    write_imm(1, 32'd5);
    write_imm(2, 32'd7);
    set_ctrl(1, 2, 3, 1'b1, OP_A_RS1, OP_B_RS2, RD_SEL_ALU, ALU_ADD, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
    launch();
    check("add_done", done_o === 1'b1);
    check("add_ready_exec", ready_o === 1'b0);
    check("add_jump", jump_target_o === 32'hC);
    check("add_cond", branch_cond_o === 1'b0);
    tick();
    check("add_ready_after", ready_o === 1'b1);
    check("add_done_after", done_o === 1'b0);
    read_reg(3, rv);
    check("add_x3", rv === 32'd12);

    set_ctrl(1, 2, 4, 1'b1, OP_A_RS1, OP_B_RS2, RD_SEL_ALU, ALU_SLT, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
    launch();
    check("slt_cond", branch_cond_o === 1'b1);
    tick();
    read_reg(4, rv);
    check("slt_x4", rv === 32'd1);

    set_ctrl(1, 2, 10, 1'b1, OP_A_RS1, OP_B_RS2, RD_SEL_ALU, ALU_SUB, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
    launch();
    check("sub_jump", jump_target_o === 32'hFFFF_FFFE);
    tick();
    read_reg(10, rv);
    check("sub_x10", rv === 32'hFFFF_FFFE);

    set_ctrl(0, 0, 5, 1'b1, OP_A_PC, OP_B_IMM, RD_SEL_PC_INC, ALU_ADD, 1'b0, LSU_WORD, 1'b0, 32'h1000, 32'h23);
    launch();
    check("jal_jump", jump_target_o === 32'h1022);
    check("jal_cond", branch_cond_o === 1'b1);
    tick();
    read_reg(5, rv);
    check("jal_x5", rv === 32'h1004);

    write_imm(2, 32'hDEAD_BEEF);
    set_ctrl(0, 2, 0, 1'b0, OP_A_RS1, OP_B_IMM, RD_SEL_ALU, ALU_ADD, 1'b1, LSU_WORD, 1'b0, 32'h0, 32'h100);
    launch();
    check("sw_exec_req", data_req_o === 1'b0);
    check("sw_exec_done", done_o === 1'b0);
    data_rvalid_i = 1'b1;
    tick();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (data_req_o) req_cycles++;
      check("sw_wait_addr", data_addr_o === 32'h100);
      check("sw_wait_done", done_o === 1'b0);
      tick();
    end
    data_rvalid_i = 1'b0;
    data_gnt_i = 1'b1;
    if (data_req_o) req_cycles++;
    check("sw_be", data_be_o === 4'b1111);
    check("sw_we", data_we_o === 1'b1);
    check("sw_wdata", data_wdata_o === 32'hDEAD_BEEF);
    tick();
    data_gnt_i = 1'b0;
    check("sw_req_cycles", req_cycles === 4);
    check("sw_memwait_req", data_req_o === 1'b0);
    check("sw_memwait_done", done_o === 1'b0);
    tick();
    data_rvalid_i = 1'b1;
    #1;
    check("sw_done", done_o === 1'b1);
    tick();
    data_rvalid_i = 1'b0;
    check("sw_ready", ready_o === 1'b1);

    mem_store(2, LSU_BYTE, 32'h101, a_obs, be_obs, we_obs, wd_obs);
    check("sb_be", be_obs === 4'b0010);
    check("sb_wdata", wd_obs === 32'hEFEF_EFEF);
    mem_store(2, LSU_HALF, 32'h102, a_obs, be_obs, we_obs, wd_obs);
    check("sh_addr", a_obs === 32'h100);
    check("sh_be", be_obs === 4'b1100);
    check("sh_wdata", wd_obs === 32'hBEEF_BEEF);

    mem_load(6, LSU_BYTE, 1'b0, 32'h103, 32'h8012_3456, a_obs, be_obs, done_obs, mis_obs);
    check("lb_addr", a_obs === 32'h100);
    check("lb_be", be_obs === 4'b1000);
    check("lb_done", done_obs === 1'b1);
    read_reg(6, rv);
    check("lb_x6", rv === 32'hFFFF_FF80);
    mem_load(7, LSU_BYTE, 1'b1, 32'h103, 32'h8012_3456, a_obs, be_obs, done_obs, mis_obs);
    read_reg(7, rv);
    check("lbu_x7", rv === 32'h0000_0080);
    mem_load(11, LSU_HALF, 1'b0, 32'h102, 32'hF00D_1234, a_obs, be_obs, done_obs, mis_obs);
    check("lh_be", be_obs === 4'b1100);
    check("lh_mis", mis_obs === 1'b0);
    read_reg(11, rv);
    check("lh_x11", rv === 32'hFFFF_F00D);
    mem_load(12, LSU_HALF, 1'b1, 32'h100, 32'hF00D_8234, a_obs, be_obs, done_obs, mis_obs);
    check("lhu_be", be_obs === 4'b0011);
    read_reg(12, rv);
    check("lhu_x12", rv === 32'h0000_8234);

    write_imm(8, 32'h11);
    set_ctrl(0, 0, 8, 1'b1, OP_A_RS1, OP_B_IMM, RD_SEL_LOAD, ALU_ADD, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h102);
    launch();
`ifdef PANDA_MISALIGNED_CHECK_EN
    check("lw_mis_done", done_o === 1'b1);
    check("lw_mis_flag", misaligned_o === 1'b1);
    check("lw_mis_req_exec", data_req_o === 1'b0);
    tick();
    check("lw_mis_req_after", data_req_o === 1'b0);
    read_reg(8, rv);
    check("lw_mis_x8", rv === 32'h11);
`else
    check("lw_exec_done", done_o === 1'b0);
    tick();
    check("lw_req", data_req_o === 1'b1);
    check("lw_addr", data_addr_o === 32'h100);
    check("lw_be", data_be_o === 4'b1111);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    data_rdata_i = 32'hCAFE_F00D;
    data_rvalid_i = 1'b1;
    #1;
    check("lw_done", done_o === 1'b1);
    check("lw_mis", misaligned_o === 1'b0);
    tick();
    data_rvalid_i = 1'b0;
    read_reg(8, rv);
    check("lw_x8", rv === 32'hCAFE_F00D);
`endif

    write_imm(9, 32'h22);
    set_ctrl(0, 0, 9, 1'b1, OP_A_RS1, OP_B_IMM, RD_SEL_LOAD, ALU_ADD, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h200);
    launch();
    tick();
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    check("rstw_memwait_req", data_req_o === 1'b0);
    rst_ni = 1'b0;
    #1;
    check("rstw_ready", ready_o === 1'b1);
    check("rstw_done", done_o === 1'b0);
    check("rstw_we", data_we_o === 1'b0);
    check("rstw_be", data_be_o === 4'b0000);
    #2;
    rst_ni = 1'b1;
    data_rdata_i = 32'h1234_5678;
    data_rvalid_i = 1'b1;
    tick();
    check("rstw_late_done", done_o === 1'b0);
    check("rstw_late_ready", ready_o === 1'b1);
    tick();
    check("rstw_late_done2", done_o === 1'b0);
    data_rvalid_i = 1'b0;
    read_reg(9, rv);
    check("rstw_x9", rv === 32'h0);
    read_reg(1, rv);
    check("rstw_x1", rv === 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/panda_mc_datapath.md
PANDA_MC_DATAPATH -- requirements
Module: panda_mc_datapath

Interface
REQ-001 SHALL have parameter NumRegs, default 32, meaning the register count; legal values 16 (RV32E) or 32; RegAw = $clog2(NumRegs).
REQ-002 SHALL have parameter Width, default 32, meaning the data width; only 32 is legal, and elaboration SHALL fail otherwise.
REQ-003 clk_i  input  1  clock; the block has one clock.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 valid_i  input  1  instruction controls valid.
REQ-006 ready_o  output  1  datapath idle; accepts controls.
REQ-007 rs1_addr_i  input  RegAw  source 1 register address.
REQ-008 rs2_addr_i  input  RegAw  source 2 register address.
REQ-009 rd_addr_i  input  RegAw  destination register address.
REQ-010 rd_we_i  input  1  destination write enable.
REQ-011 op_a_sel_i  input  op_a_sel_e  ALU operand A select (RS1/PC).
REQ-012 op_b_sel_i  input  op_b_sel_e  ALU operand B select (RS2/IMM).
REQ-013 rd_data_sel_i  input  rd_data_sel_e  writeback select (ALU/LOAD/PC_INC/IMM).
REQ-014 alu_operator_i  input  alu_operator_e  ALU function.
REQ-015 lsu_store_i  input  1  instruction is a store.
REQ-016 lsu_width_i  input  lsu_width_e  access width (byte/half/word).
REQ-017 lsu_load_unsigned_i  input  1  zero-extend the load.
REQ-018 pc_i  input  32  instruction PC.
REQ-019 imm_i  input  32  decoded immediate.
REQ-020 data_req_o  output  1  memory request.
REQ-021 data_gnt_i  input  1  memory request granted.
REQ-022 data_rvalid_i  input  1  memory response valid.
REQ-023 data_addr_o  output  32  word-aligned address.
REQ-024 data_we_o  output  1  write request.
REQ-025 data_be_o  output  4  byte enables.
REQ-026 data_wdata_o  output  32  store data, lane-replicated.
REQ-027 data_rdata_i  input  32  load data.
REQ-028 done_o  output  1  one-cycle pulse marking instruction retire.
REQ-029 jump_target_o  output  32  {alu_result[31:1],1'b0}, valid in the done_o cycle.
REQ-030 branch_cond_o  output  1  alu_result[0], valid in the done_o cycle.
REQ-031 misaligned_o  output  1  misaligned-access flag, qualified by done_o.

Function
REQ-032 SHALL implement the FSM IDLE->EXEC->{IDLE | MEM_REQ->MEM_WAIT->IDLE}:
- ready_o=1 only in IDLE.
- valid_i&&ready_o latches all control inputs plus pc_i and imm_i.
REQ-033 EXEC: read the register file using the latched addresses and compute the ALU result.
- A memory op (lsu_store or rd_data_sel==LOAD) registers the address and byte enables and goes to MEM_REQ.
- Otherwise the cycle writes back, pulses done_o and returns to IDLE (2-cycle latency).
REQ-034 MEM_REQ: hold data_req_o=1 with stable addr/we/be/wdata until data_gnt_i=1, then go to MEM_WAIT; a grant in the first cycle is legal.
REQ-035 MEM_WAIT: data_req_o=0; on data_rvalid_i, write back (loads only), pulse done_o and return to IDLE.
- data_rvalid_i in IDLE/EXEC/MEM_REQ SHALL be ignored.
REQ-036 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Store data: byte lane-replicated x4, half replicated x2.
- Load: the selected lane is sign- or zero-extended per the latched unsigned flag.
REQ-037 PC_INC writeback = latched pc+4, computed internally.
REQ-038 Writes to x0 SHALL be discarded; x0 reads 0.
- Reads of addresses >= NumRegs SHALL return 0, and writes to them are discarded.

Reset
REQ-039 Async reset, effective mid-operation, SHALL:
- force IDLE;
- drop data_req_o;
- clear all latched controls and done_o/misaligned_o/data_we_o/data_be_o to 0;
- clear registers x1..xN to 0.
A response arriving after reset SHALL be ignored.

Configuration
REQ-040 With PANDA_MISALIGNED_CHECK_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL issue no request.
- EXEC pulses done_o with misaligned_o=1 and suppresses the register write.
REQ-041 Without PANDA_MISALIGNED_CHECK_EN, misaligned_o SHALL be tied 0 and accesses proceed:
- half uses addr[1] only;
- word ignores addr[1:0].

Structure
REQ-042 The new mc_state_e enum SHALL live in panda_pkg; the existing select and operator enums are reused from there.
REQ-043 The register file SHALL be the existing panda_register_file instance with Depth=NumRegs; the ALU SHALL be the existing panda_alu instance.
- The new sub-module panda_mc_lsu SHALL provide the byte-enable, replication and extension logic.

Verification
REQ-044 ADD x3=x1(5)+x2(7): valid in cycle 0 -> done_o in cycle 1, x3=12, ready_o=1 in cycle 2.
REQ-045 SW x2(0xDEADBEEF)->0x100, gnt delayed 3 cycles -> req held 4 cycles at addr 0x100 with be=1111; done on rvalid.
REQ-046 LB from 0x103 with rdata=0x80xxxxxx -> rd=0xFFFFFF80; LBU -> 0x00000080.
REQ-047 LH from 0x102 with the macro defined -> misaligned_o=0; LW from 0x102 -> no req, misaligned_o=1, rd unchanged.
REQ-048 rst_ni asserted in MEM_WAIT, later rvalid -> IDLE, no writeback, no done_o.
